// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I core pipeline control.
// Forwarding select encoding and hazard FSM states.
package core_pkg;

    localparam int unsigned CORE_REGW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage forwarding select for one ALU operand.
// The Memory stage wins over Writeback, and x0 never forwards.
module fwd_unit
    import core_pkg::*;
#(
    parameter int unsigned REGW = CORE_REGW
) (
    input  logic [REGW-1:0] src,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            regwriteM,
    input  logic            regwriteW,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_REG;
        if (regwriteM && (rdM != '0) && (rdM == src)) begin
            sel = FWD_M;
        end else if (regwriteW && (rdW != '0) && (rdW == src)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline enable/flush generation, E-stage forwarding selects,
// memory-wait FSM with watchdog, and stall-cycle counter.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int unsigned REGW    = CORE_REGW,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rs1E,
    input  logic [REGW-1:0] rs2E,
    input  logic [REGW-1:0] rdE,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            loadE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            pcsrcE,
    input  logic            memreqM,
    input  logic            dmem_ready,
    output logic            enF,
    output logic            enD,
    output logic            enE,
    output logic            enM,
    output logic            flushD,
    output logic            flushE,
    output logic            flushW,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned WCW = $clog2(TIMEOUT);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           err_set;
    logic           memwait;
    logic           lu;

    assign memwait = memreqM & ~dmem_ready;
    assign lu      = loadE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

    always_comb begin
        enF    = 1'b1;
        enD    = 1'b1;
        enE    = 1'b1;
        enM    = 1'b1;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (reset_n) begin
            if (memwait) begin
                enF    = 1'b0;
                enD    = 1'b0;
                enE    = 1'b0;
                enM    = 1'b0;
                flushW = 1'b1;
            end else if (pcsrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lu) begin
                enF    = 1'b0;
                enD    = 1'b0;
                flushE = 1'b1;
            end
        end
    end

    // wait_cnt counts elapsed wait cycles, so the RUN cycle that first sees
    // memwait loads 1; the watchdog then trips after exactly TIMEOUT cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_set = 1'b0;
        case (state_q)
            RUN: begin
                if (memwait) begin
                    state_d = MEM_WAIT;
                    wait_d  = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!memwait) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (!enF && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    fwd_unit #(.REGW(REGW)) u_fwd_a (
        .src       (rs1E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .sel       (forwardAE)
    );

    fwd_unit #(.REGW(REGW)) u_fwd_b (
        .src       (rs2E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .sel       (forwardBE)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: expected outputs queued per step,
// popped and checked mid-cycle on the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [6:0] NORMAL = 7'b1111_000;
    localparam logic [6:0] MEMW   = 7'b0000_001;
    localparam logic [6:0] BR     = 7'b1111_110;
    localparam logic [6:0] LU     = 7'b0011_010;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       loadE, regwriteM, regwriteW, pcsrcE, memreqM, dmem_ready;
    logic       enF, enD, enE, enM, flushD, flushE, flushW;
    logic [1:0] forwardAE, forwardBE;
    logic       mem_err;
    logic [4:0] stall_cnt;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       merr;
        logic [4:0] sc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    hazard_stall_ctrl #(.REGW(5), .TIMEOUT(16), .CNTW(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .rdM        (rdM),
        .rdW        (rdW),
        .loadE      (loadE),
        .regwriteM  (regwriteM),
        .regwriteW  (regwriteW),
        .pcsrcE     (pcsrcE),
        .memreqM    (memreqM),
        .dmem_ready (dmem_ready),
        .enF        (enF),
        .enD        (enD),
        .enE        (enE),
        .enM        (enM),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushW     (flushW),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] fwd_ref(input logic [4:0] s, input logic [4:0] m,
                                           input logic [4:0] w, input logic wm, input logic ww);
        if (wm && (m != 5'd0) && (m == s)) return 2'b10;
        if (ww && (w != 5'd0) && (w == s)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_one();
        exp_t       e;
        logic [6:0] ctrl_obs;
        logic [3:0] fwd_obs, fwd_exp;
        logic [5:0] cnt_obs, cnt_exp;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected>0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            ctrl_obs = {enF, enD, enE, enM, flushD, flushE, flushW};
            fwd_obs  = {forwardAE, forwardBE};
            fwd_exp  = {e.fa, e.fb};
            cnt_obs  = {mem_err, stall_cnt};
            cnt_exp  = {e.merr, e.sc};
            total++;
            assert (ctrl_obs === e.ctrl) else begin
                bad++;
                $error("FAIL %s ctrl observed=%b expected=%b", e.tag, ctrl_obs, e.ctrl);
            end
            total++;
            assert (fwd_obs === fwd_exp) else begin
                bad++;
                $error("FAIL %s fwd observed=%b expected=%b", e.tag, fwd_obs, fwd_exp);
            end
            total++;
            assert (cnt_obs === cnt_exp) else begin
                bad++;
                $error("FAIL %s err_cnt observed=%b expected=%b", e.tag, cnt_obs, cnt_exp);
            end
        end
    endtask

    task automatic step(input string tag, input logic [6:0] ctrl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic merr, input logic [4:0] sc);
        exp_t e;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.fa   = fa;
        e.fb   = fb;
        e.merr = merr;
        e.sc   = sc;
        sb.push_back(e);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {loadE, regwriteM, regwriteW, pcsrcE} = '0;
        memreqM    = 1'b1;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold", NORMAL, 2'b00, 2'b00, 1'b0, 5'd0);

        reset_n = 1'b1;
        step("mw_pre1", MEMW, 2'b00, 2'b00, 1'b0, 5'd0);
        step("mw_pre2", MEMW, 2'b00, 2'b00, 1'b0, 5'd1);
        reset_n = 1'b0;
        step("reset_midwait", NORMAL, 2'b00, 2'b00, 1'b0, 5'd0);
        reset_n = 1'b1;
        memreqM = 1'b0;
        step("idle", NORMAL, 2'b00, 2'b00, 1'b0, 5'd0);

        loadE = 1'b1; rdE = 5'd5; rs1D = 5'd3; rs2D = 5'd5;
        step("lu", LU, 2'b00, 2'b00, 1'b0, 5'd0);
        loadE = 1'b0;
        step("lu_after", NORMAL, 2'b00, 2'b00, 1'b0, 5'd1);
        loadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        step("lu_x0", NORMAL, 2'b00, 2'b00, 1'b0, 5'd1);
        loadE = 1'b0;

        memreqM = 1'b1; dmem_ready = 1'b0;
        step("mw1", MEMW, 2'b00, 2'b00, 1'b0, 5'd1);
        pcsrcE = 1'b1;
        step("mw2_branch_ignored", MEMW, 2'b00, 2'b00, 1'b0, 5'd2);
        pcsrcE = 1'b0;
        step("mw3", MEMW, 2'b00, 2'b00, 1'b0, 5'd3);
        dmem_ready = 1'b1;
        step("mw_release", NORMAL, 2'b00, 2'b00, 1'b0, 5'd4);
        memreqM = 1'b0; dmem_ready = 1'b0;
        step("mw_idle", NORMAL, 2'b00, 2'b00, 1'b0, 5'd4);

        pcsrcE = 1'b1; loadE = 1'b1; rdE = 5'd5; rs2D = 5'd5;
        step("branch_over_lu", BR, 2'b00, 2'b00, 1'b0, 5'd4);
        pcsrcE = 1'b0; loadE = 1'b0;
        step("branch_after", NORMAL, 2'b00, 2'b00, 1'b0, 5'd4);

        memreqM = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step($sformatf("wdog%0d", k), MEMW, 2'b00, 2'b00, (k >= 17), 5'(4 + k - 1));
        end
        dmem_ready = 1'b1;
        step("wdog_release", NORMAL, 2'b00, 2'b00, 1'b1, 5'd24);
        memreqM = 1'b0; dmem_ready = 1'b0;
        step("wdog_sticky", NORMAL, 2'b00, 2'b00, 1'b1, 5'd24);

        rs1E = 5'd7; rs2E = 5'd9; rdM = 5'd7; rdW = 5'd7; regwriteM = 1'b1; regwriteW = 1'b1;
        step("fwd_m_prio", NORMAL, 2'b10, 2'b00, 1'b1, 5'd24);
        regwriteM = 1'b0;
        step("fwd_w", NORMAL, 2'b01, 2'b00, 1'b1, 5'd24);
        regwriteM = 1'b1; rdM = 5'd0; rdW = 5'd0;
        step("fwd_x0", NORMAL, 2'b00, 2'b00, 1'b1, 5'd24);
        rs2E = 5'd7; rdM = 5'd3; rdW = 5'd7;
        step("fwd_b_w", NORMAL, 2'b01, 2'b01, 1'b1, 5'd24);
        for (int i = 0; i < 16; i++) begin
            rs1E = 5'($urandom_range(0, 3));
            rs2E = 5'($urandom_range(0, 3));
            rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            step($sformatf("fwd_rnd%0d", i), NORMAL,
                 fwd_ref(rs1E, rdM, rdW, regwriteM, regwriteW),
                 fwd_ref(rs2E, rdM, rdW, regwriteM, regwriteW), 1'b1, 5'd24);
        end
        {rs1E, rs2E, rdM, rdW, regwriteM, regwriteW} = '0;

        memreqM = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step($sformatf("sat%0d", k), MEMW, 2'b00, 2'b00, 1'b1,
                 (24 + k - 1 > 31) ? 5'd31 : 5'(24 + k - 1));
        end
        dmem_ready = 1'b1;
        step("sat_release", NORMAL, 2'b00, 2'b00, 1'b1, 5'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Generates the enable and flush controls consumed by the F/D/E/M/W pipeline registers (enabled, resettable flops) of the 5-stage RV32I core, plus E-stage forwarding selects.
- Detects load-use hazards, taken-branch redirects and data-memory wait states.
- Holds a small FSM for multi-cycle memory stalls, with a timeout watchdog and a stall-cycle performance counter.
- Sits beside the datapath. It is the driver end of every pipeline-register en/reset pin.

Parameters:
- REGW, 5, register index width
- TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before the watchdog trips (>=2)
- CNTW, 32, width of the stall performance counter

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs1D  in  REGW  source 1 of the instruction in Decode
- rs2D  in  REGW  source 2 of the instruction in Decode
- rs1E  in  REGW  source 1 of the instruction in Execute
- rs2E  in  REGW  source 2 of the instruction in Execute
- rdE  in  REGW  destination in Execute
- rdM  in  REGW  destination in Memory
- rdW  in  REGW  destination in Writeback
- loadE  in  1  Execute instruction is a load
- regwriteM  in  1  Memory stage writes the register file
- regwriteW  in  1  Writeback stage writes the register file
- pcsrcE  in  1  taken branch/jump resolved in Execute
- memreqM  in  1  Memory stage issues a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- enF  out  1  PC register enable
- enD  out  1  F/D register enable
- enE  out  1  D/E register enable
- enM  out  1  E/M register enable
- flushD  out  1  F/D synchronous clear
- flushE  out  1  D/E synchronous clear
- flushW  out  1  M/W synchronous clear (bubble insertion)
- forwardAE  out  2  ALU A select: 00 regfile, 01 W result, 10 M ALU result
- forwardBE  out  2  ALU B select, same encoding
- mem_err  out  1  sticky watchdog flag
- stall_cnt  out  CNTW  total stall cycles since reset

Behaviour:
- Reset (reset_n=0, asynchronous): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0. While in reset all en*=1 and all flush*=0.
- FSM states: RUN, MEM_WAIT. Control outputs are combinational from state plus inputs, so they act in the same cycle.
- memwait = memreqM & ~dmem_ready.
- Load-use (lu): loadE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- Priority 1, memwait (either state): enF=enD=enE=enM=0, flushW=1, flushD=flushE=0. pcsrcE and lu are ignored and re-evaluated after release.
  - RUN->MEM_WAIT at the clock edge.
  - In MEM_WAIT, wait_cnt increments each cycle.
- MEM_WAIT exit: dmem_ready=1 releases. Outputs return to normal that cycle, the state goes to RUN and wait_cnt clears.
- Watchdog: if wait_cnt reaches TIMEOUT-1 while still waiting, mem_err sets (sticky until reset), state goes to RUN and wait_cnt clears. The stall persists as long as memwait stays 1; the watchdog only flags.
- Priority 2, pcsrcE: flushD=1, flushE=1, all enables 1.
- Priority 3, lu: enF=enD=0, flushE=1 (one bubble). Exactly one cycle per load-use pair.
- pcsrcE and lu in the same cycle: only the branch flush applies, because the wrong-path instruction is discarded.
- Default: all en=1, all flush=0.
- stall_cnt increments by 1 in any cycle where enF=0, and saturates at all-ones.
- Forwarding, per source s in {rs1E, rs2E}:
  - 10 if regwriteM & rdM!=0 & rdM==s.
  - Else 01 if regwriteW & rdW!=0 & rdW==s.
  - Else 00.
  - M has priority over W. x0 is never forwarded.
- Reset mid-MEM_WAIT: immediate return to RUN, counters cleared.

Decomposition:
- Shared package (core_pkg):
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - FSM state encoding (RUN=0, MEM_WAIT=1)
  - REGW constant
- One sub-module, fwd_unit (purely combinational forwarding compare), instantiated once per ALU operand.

Test Plan:
- Reset: reset_n=0 at cycle 3 with memreqM=1, dmem_ready=0 -> state RUN, stall_cnt=0, mem_err=0, all en=1.
- Load-use: loadE=1, rdE=5, rs2D=5 for one cycle -> enF=enD=0, flushE=1 for exactly 1 cycle, stall_cnt=1. Repeat with rdE=0 -> no stall.
- Memory wait: memreqM=1, dmem_ready=0 for 3 cycles, then 1 -> enF..enM=0 and flushW=1 for 3 cycles, resume on cycle 4, stall_cnt=3, mem_err=0.
- Watchdog: dmem_ready held 0 for 20 cycles with TIMEOUT=16 -> mem_err=1 after 16 wait cycles and stays 1. Stall persists until dmem_ready=1.
- Branch vs load-use: pcsrcE=1 and lu=1 together -> flushD=flushE=1, enF=enD=1, stall_cnt unchanged.
- Forwarding: rs1E=7, rdM=7, regwriteM=1, rdW=7, regwriteW=1 -> forwardAE=10. With regwriteM=0 -> 01. With rdM=rdW=0 -> 00.
